// File: rtl/tile_dump_writer.sv
// tile_dump_writer
// Streams one tile_size x tile_size tile of pixels from the sprite unit into
// a linear framebuffer. Each pixel takes one request cycle (WAIT), one
// capture cycle (CAPTURE) and at least one write cycle (WRITE). Pixels are
// visited in raster order, x fastest.
//
// Ports
//   i_clock, i_reset          : clock, synchronous active-high reset
//   i_start                   : begin a tile (accepted only while idle)
//   i_tile_x, i_tile_y        : tile coordinates, latched at start
//   i_framebuffer_address     : framebuffer byte base, latched at start
//   i_stride_pixels           : framebuffer row width in pixels, latched at start
//   o_busy, o_done            : tile in progress / one-cycle completion pulse
//   o_start_dump, o_next_dump : pixel requests to the sprite unit
//   i_dump_color              : RGB returned the cycle after a request
//   o_mem_write, o_mem_address, o_mem_data, i_mem_ready : write port
module tile_dump_writer #(
  parameter int tile_size        = 10,
  parameter int tile_number_bits = 7
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic [tile_number_bits-1:0] i_tile_x,
  input  logic [tile_number_bits-1:0] i_tile_y,
  input  logic [31:0]                 i_framebuffer_address,
  input  logic [15:0]                 i_stride_pixels,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_start_dump,
  output logic                        o_next_dump,
  input  logic [23:0]                 i_dump_color,
  output logic                        o_mem_write,
  output logic [31:0]                 o_mem_address,
  output logic [31:0]                 o_mem_data,
  input  logic                        i_mem_ready
);

  typedef enum logic [2:0] {IDLE, WAIT, CAPTURE, WRITE, DONE} state_t;

  localparam logic [7:0]  LAST = 8'(tile_size - 1);
  localparam logic [31:0] TS   = 32'(tile_size);

  state_t state, state_n;

  logic [tile_number_bits-1:0] tile_x, tile_y;
  logic [31:0] base;
  logic [15:0] stride;
  logic [7:0]  px, py, px_n, py_n;
  logic [31:0] pix_addr;
  logic        last_pix;
  logic        busy_n, done_n, start_dump_n, next_dump_n, mem_write_n;

  assign last_pix = (px == LAST) && (py == LAST);

  // Byte address of the current pixel; all arithmetic wraps at 32 bits.
  assign pix_addr = base + (((32'(tile_y) * TS + 32'(py)) * 32'(stride)
                             + 32'(tile_x) * TS + 32'(px)) << 2);

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (i_start) state_n = WAIT;
      WAIT:    state_n = CAPTURE;
      CAPTURE: state_n = WRITE;
      WRITE:   if (i_mem_ready) state_n = last_pix ? DONE : WAIT;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output logic: computes the next value of every registered output from
  // the next state, so the outputs line up with the state they belong to
  // while still having no combinational path from any input.
  always_comb begin
    px_n = px;
    py_n = py;
    if (state == IDLE && i_start) begin
      px_n = '0;
      py_n = '0;
    end else if (state == WRITE && i_mem_ready && !last_pix) begin
      if (px == LAST) begin
        px_n = '0;
        py_n = py + 8'd1;
      end else begin
        px_n = px + 8'd1;
      end
    end
    busy_n       = (state_n != IDLE);
    done_n       = (state_n == DONE);
    mem_write_n  = (state_n == WRITE);
    start_dump_n = (state_n == WAIT) && (px_n == '0) && (py_n == '0);
    next_dump_n  = (state_n == WAIT) && !((px_n == '0) && (py_n == '0));
  end

  // Datapath and registered outputs
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      px            <= '0;
      py            <= '0;
      tile_x        <= '0;
      tile_y        <= '0;
      base          <= '0;
      stride        <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_start_dump  <= 1'b0;
      o_next_dump   <= 1'b0;
      o_mem_write   <= 1'b0;
      o_mem_address <= '0;
      o_mem_data    <= '0;
    end else begin
      px           <= px_n;
      py           <= py_n;
      o_busy       <= busy_n;
      o_done       <= done_n;
      o_start_dump <= start_dump_n;
      o_next_dump  <= next_dump_n;
      o_mem_write  <= mem_write_n;
      if (state == IDLE && i_start) begin
        tile_x <= i_tile_x;
        tile_y <= i_tile_y;
        base   <= i_framebuffer_address;
        stride <= i_stride_pixels;
      end
      // Colour is valid the cycle after the request, i.e. during CAPTURE;
      // address and data then hold through WRITE until accepted.
      if (state == CAPTURE) begin
        o_mem_address <= pix_addr;
        o_mem_data    <= {8'h00, i_dump_color};
      end
    end
  end

endmodule

// File: tb/tb_tile_dump_writer.sv
// Self-checking bench for tile_dump_writer: table of tile configurations with
// spot-checked addresses, randomized tiles/backpressure against a reference
// list of addresses and colours, plus hand sequences for reset and backpressure.
module tb_tile_dump_writer;

  localparam int TS = 10;
  localparam int NPIX = TS * TS;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [6:0]  i_tile_x, i_tile_y;
  logic [31:0] i_framebuffer_address;
  logic [15:0] i_stride_pixels;
  logic        o_busy, o_done, o_start_dump, o_next_dump;
  logic [23:0] i_dump_color;
  logic        o_mem_write;
  logic [31:0] o_mem_address, o_mem_data;
  logic        i_mem_ready;

  tile_dump_writer #(.tile_size(TS), .tile_number_bits(7)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
    .i_tile_x(i_tile_x), .i_tile_y(i_tile_y),
    .i_framebuffer_address(i_framebuffer_address),
    .i_stride_pixels(i_stride_pixels),
    .o_busy(o_busy), .o_done(o_done),
    .o_start_dump(o_start_dump), .o_next_dump(o_next_dump),
    .i_dump_color(i_dump_color),
    .o_mem_write(o_mem_write), .o_mem_address(o_mem_address),
    .o_mem_data(o_mem_data), .i_mem_ready(i_mem_ready)
  );

  always #5 i_clock = ~i_clock;

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference state
  logic [31:0] exp_q[$];
  logic [23:0] col_q[$];
  logic [31:0] wr_log[$];
  int wr_cnt, sd_cnt, nd_cnt, done_cnt, done_cyc, stall_cnt, stall_left;
  bit done_seen, req_prev, held;
  logic [31:0] hold_a, hold_d;
  int rmode = 0;

  // Ready / colour driver
  always @(posedge i_clock) begin
    #1;
    i_dump_color = 24'($urandom);
    case (rmode)
      0:       i_mem_ready = 1'b1;
      1:       i_mem_ready = ($urandom_range(0, 9) < 7);
      default: i_mem_ready = (stall_left == 0);
    endcase
  end

  // Monitor
  always @(negedge i_clock) begin
    if (i_reset) begin
      req_prev = 0;
      held = 0;
    end else begin
      if (req_prev) col_q.push_back(i_dump_color);
      req_prev = o_start_dump | o_next_dump;
      if (o_start_dump) sd_cnt++;
      if (o_next_dump) nd_cnt++;
      chk("req_exclusive", {63'd0, o_start_dump & o_next_dump}, 64'd0);
      chk("req_during_write", {63'd0, o_mem_write & (o_start_dump | o_next_dump)}, 64'd0);
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        done_seen = 1;
        chk("busy_in_done", {63'd0, o_busy}, 64'd1);
      end
      if (o_mem_write) begin
        if (held) begin
          chk("hold_addr", {32'd0, o_mem_address}, {32'd0, hold_a});
          chk("hold_data", {32'd0, o_mem_data}, {32'd0, hold_d});
        end
        if (i_mem_ready) begin
          wr_cnt++;
          wr_log.push_back(o_mem_address);
          if (exp_q.size() == 0) chk("extra_write", 64'd1, 64'd0);
          else chk("write_addr", {32'd0, o_mem_address}, {32'd0, exp_q.pop_front()});
          if (col_q.size() == 0) chk("data_no_request", 64'd1, 64'd0);
          else chk("write_data", {32'd0, o_mem_data}, {40'd0, col_q.pop_front()});
          held = 0;
        end else begin
          stall_cnt++;
          if (stall_left > 0) stall_left--;
          held = 1;
          hold_a = o_mem_address;
          hold_d = o_mem_data;
        end
      end
    end
  end

  // Build expected addresses from the tile geometry.
  task automatic prep(input int tx, input int ty, input logic [31:0] base,
                      input logic [15:0] stride, input int mode);
    longint off;
    exp_q.delete(); col_q.delete(); wr_log.delete();
    wr_cnt = 0; sd_cnt = 0; nd_cnt = 0; done_cnt = 0; done_cyc = 0;
    stall_cnt = 0; stall_left = 5; done_seen = 0;
    rmode = mode;
    for (int y = 0; y < TS; y++)
      for (int x = 0; x < TS; x++) begin
        off = ((longint'(ty) * TS + y) * longint'(stride) + longint'(tx) * TS + x) * 4;
        exp_q.push_back(base + 32'(off));
      end
  endtask

  task automatic kick(input int tx, input int ty, input logic [31:0] base,
                      input logic [15:0] stride, output int c0);
    @(posedge i_clock); #1;
    i_tile_x = 7'(tx); i_tile_y = 7'(ty);
    i_framebuffer_address = base; i_stride_pixels = stride;
    i_start = 1'b1;
    @(posedge i_clock); #1;
    c0 = cyc;
    i_start = 1'b0;
    // Scramble the inputs: the block must use its latched copies.
    i_tile_x = 7'($urandom); i_tile_y = 7'($urandom);
    i_framebuffer_address = $urandom; i_stride_pixels = 16'($urandom);
  endtask

  task automatic run_tile(input int tx, input int ty, input logic [31:0] base,
                          input logic [15:0] stride, input int mode,
                          input bit mid_start, input int chk_idx,
                          input logic [31:0] chk_addr);
    int c0;
    prep(tx, ty, base, stride, mode);
    kick(tx, ty, base, stride, c0);
    for (int n = 0; n < 3000 && !done_seen; n++) begin
      @(posedge i_clock); #1;
      if (mid_start) i_start = (n == 40);
    end
    i_start = 1'b0;
    if (!done_seen) chk("done_timeout", 64'd0, 64'd1);
    @(negedge i_clock);
    chk("busy_after_done", {63'd0, o_busy}, 64'd0);
    chk("write_count", 64'(wr_cnt), 64'(NPIX));
    chk("start_dump_count", 64'(sd_cnt), 64'd1);
    chk("next_dump_count", 64'(nd_cnt), 64'(NPIX - 1));
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("done_cycle", 64'(done_cyc - c0 + 1), 64'(3 * NPIX + 1 + stall_cnt));
    if (mode == 2) chk("stall_count", 64'(stall_cnt), 64'd5);
    if (chk_idx >= 0 && chk_idx < wr_log.size())
      chk("spot_addr", {32'd0, wr_log[chk_idx]}, {32'd0, chk_addr});
    else if (chk_idx >= 0)
      chk("spot_missing", 64'(wr_log.size()), 64'(chk_idx + 1));
  endtask

  typedef struct {
    int          tx, ty;
    logic [31:0] base;
    logic [15:0] stride;
    int          mode;
    int          chk_idx;
    logic [31:0] chk_addr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int c0, sd0, nd0;
    vecs[0] = '{0, 0, 32'h1000_0000, 16'd640, 0, 0,  32'h1000_0000};
    vecs[1] = '{0, 0, 32'h1000_0000, 16'd640, 0, 10, 32'h1000_0A00};
    vecs[2] = '{0, 0, 32'h1000_0000, 16'd640, 0, 99, 32'h1000_5A24};
    vecs[3] = '{3, 2, 32'h1000_0000, 16'd640, 0, 0,  32'h1000_C878};
    vecs[4] = '{0, 0, 32'hFFFF_FFFC, 16'd640, 0, 1,  32'h0000_0000};
    vecs[5] = '{5, 7, 32'h2000_0040, 16'd1920, 1, 11, 32'h2000_0040 + 32'(((70 + 1) * 1920 + 50 + 1) * 4)};

    i_reset = 1'b1; i_start = 1'b1;
    i_tile_x = '0; i_tile_y = '0; i_framebuffer_address = '0; i_stride_pixels = '0;
    i_mem_ready = 1'b1; i_dump_color = '0;
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    chk("rst_outputs", {o_busy, o_done, o_start_dump, o_next_dump, o_mem_write},  5'd0);
    chk("rst_addr", {32'd0, o_mem_address}, 64'd0);
    chk("rst_data", {32'd0, o_mem_data}, 64'd0);
    @(posedge i_clock); #1;
    i_reset = 1'b0; i_start = 1'b0;
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    chk("idle_after_reset", {o_busy, o_start_dump, o_next_dump, o_mem_write}, 4'd0);

    foreach (vecs[i])
      run_tile(vecs[i].tx, vecs[i].ty, vecs[i].base, vecs[i].stride,
               vecs[i].mode, 1'b0, vecs[i].chk_idx, vecs[i].chk_addr);

    // Randomized tiles with random backpressure
    for (int r = 0; r < 4; r++)
      run_tile($urandom_range(0, 127), $urandom_range(0, 127), $urandom,
               16'($urandom_range(1, 65535)), 1, 1'b0, -1, 32'd0);

    // Backpressure: five stalled cycles on pixel 0
    run_tile(0, 0, 32'h1000_0000, 16'd640, 2, 1'b0, 0, 32'h1000_0000);

    // Start pulsed mid-tile is ignored
    run_tile(1, 1, 32'h1000_0000, 16'd640, 0, 1'b1, 0, 32'h1000_0000 + 32'((10 * 640 + 10) * 4));

    // Reset after the 50th accepted write
    prep(0, 0, 32'h1000_0000, 16'd640, 0);
    kick(0, 0, 32'h1000_0000, 16'd640, c0);
    for (int n = 0; n < 1000 && wr_cnt < 50; n++) begin
      @(posedge i_clock); #1;
    end
    chk("reached_50_writes", 64'(wr_cnt), 64'd50);
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    @(negedge i_clock);
    chk("midrst_outputs", {o_busy, o_done, o_start_dump, o_next_dump, o_mem_write}, 5'd0);
    chk("midrst_addr", {32'd0, o_mem_address}, 64'd0);
    sd0 = sd_cnt; nd0 = nd_cnt;
    repeat (400) @(posedge i_clock);
    @(negedge i_clock);
    chk("midrst_no_writes", 64'(wr_cnt), 64'd50);
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    chk("midrst_no_requests", 64'(sd_cnt + nd_cnt), 64'(sd0 + nd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tile_dump_writer.md
TILE_DUMP_WRITER -- requirements
Module: tile_dump_writer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be exactly the following.
- tile_size, 10: tile edge in pixels, range 1..255.
- tile_number_bits, 7: tile coordinate width.
REQ-002 Ports (name, direction, width, meaning) SHALL be exactly the following.
- i_clock, in, 1: single clock; all logic on its rising edge.
- i_reset, in, 1: synchronous, active-high reset.
- i_start, in, 1: request dump of one tile.
- i_tile_x, in, tile_number_bits: tile column.
- i_tile_y, in, tile_number_bits: tile row.
- i_framebuffer_address, in, 32: framebuffer byte base address.
- i_stride_pixels, in, 16: framebuffer row width in pixels.
- o_busy, out, 1: tile in progress.
- o_done, out, 1: one-cycle pulse on tile completion.
- o_start_dump, out, 1: to the sprite unit; first-pixel request.
- o_next_dump, out, 1: to the sprite unit; next-pixel request.
- i_dump_color, in, 24: ColorRGB from the sprite unit; R[23:16], G[15:8], B[7:0].
- o_mem_write, out, 1: write request.
- o_mem_address, out, 32: write byte address.
- o_mem_data, out, 32: write data.
- i_mem_ready, in, 1: write accepted when sampled high with o_mem_write.
REQ-003 Clock and reset: one clock, i_clock; reset i_reset is synchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE, WAIT, CAPTURE, WRITE and DONE.
REQ-005 In IDLE, i_start high SHALL latch tile_x, tile_y, base and stride, clear px and py, and move to WAIT.
- Later changes to the latched inputs SHALL have no effect until the next start.
REQ-006 In WAIT (exactly 1 cycle), the block SHALL assert o_start_dump if px=py=0, otherwise o_next_dump, then move to CAPTURE.
- The other request signal SHALL be 0 in that cycle.
REQ-007 i_dump_color SHALL be treated as valid in the cycle after o_start_dump or o_next_dump.
- CAPTURE (exactly 1 cycle) SHALL register i_dump_color and the pixel address, then move to WRITE.
REQ-008 Write data SHALL be {8'h00, i_dump_color}.
REQ-009 Write address SHALL be base + ((tile_y*tile_size + py)*stride + tile_x*tile_size + px)*4.
- Computed in 32 bits; wraps modulo 2^32.
REQ-010 In WRITE, o_mem_write SHALL be 1 and o_mem_address and o_mem_data SHALL stay stable until i_mem_ready is sampled high.
REQ-011 On write accept:
- If px=tile_size-1 and py=tile_size-1: go to DONE.
- Else if px=tile_size-1: px<=0, py<=py+1, go to WAIT.
- Else: px<=px+1, go to WAIT.
REQ-012 Pixel order SHALL be raster, x fastest; exactly tile_size^2 writes per tile.
REQ-013 DONE SHALL last 1 cycle with o_done=1, then return to IDLE.
REQ-014 o_busy SHALL be 1 in WAIT, CAPTURE, WRITE and DONE, and 0 in IDLE.
REQ-015 i_start while not in IDLE SHALL be ignored; start requests are not queued.
REQ-016 With i_mem_ready held high, each pixel SHALL take 3 cycles.
- If i_start is sampled at edge E0, o_done SHALL be high in cycle 3*tile_size^2+1 after E0.
REQ-017 o_mem_write, o_start_dump, o_next_dump and o_done SHALL be registered outputs with no combinational path from any input.

Reset
REQ-018 Reset SHALL force IDLE, clear px and py, and set o_busy, o_done, o_start_dump, o_next_dump, o_mem_write, o_mem_address and o_mem_data to 0.
REQ-019 Reset mid-tile SHALL abandon any pending write with no further write or dump request; reset SHALL take priority over i_start in the same cycle.

Verification
REQ-020 Reset check: assert i_reset with i_start=1 -> all outputs 0 next cycle; state IDLE.
REQ-021 Basic tile: tile (0,0), base 0x10000000, stride 640, ready always 1.
- Expect 100 writes: first 0x10000000, 11th 0x10000A00, last 0x10005A24.
- Data of each write = {00, color}.
- o_done in cycle 301; o_start_dump once; o_next_dump 99 times.
REQ-022 Offset tile: tile (3,2), base 0x10000000, stride 640 -> first write address 0x1000C878.
REQ-023 Backpressure: i_mem_ready=0 for 5 cycles on pixel 0.
- o_mem_write held; address and data stable.
- No o_next_dump until accept; o_done delayed by 5 cycles.
REQ-024 Busy and reset: i_start pulsed mid-tile -> ignored (still 100 writes). i_reset after the 50th accept -> no further o_mem_write; o_done never pulses.
REQ-025 Wrap: base 0xFFFFFFFC, tile (0,0), stride 640 -> second write address 0x00000000.
